// File: rtl/display_mux_ctrl.sv
// Time-multiplexed digit scheduler for a shared 7-segment decoder, with double-buffered
// digit values committed at frame boundaries. Optional blinking via DISPLAY_MUX_BLINK_EN.
module display_mux_ctrl #(
  parameter int N_DIGITS   = 4,
  parameter int PRESCALE   = 50000,
  parameter int BLANK      = 500,
  parameter int BLINK_LOG2 = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [5*N_DIGITS-1:0] diff_in,
`ifdef DISPLAY_MUX_BLINK_EN
  input  logic [N_DIGITS-1:0]   blink_mask,
`endif
  output logic [3:0]            diff,
  output logic                  sinal,
  output logic [N_DIGITS-1:0]   digit_sel,
  output logic                  frame_done,
  output logic                  load_ack
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam int IDX_W = $clog2(N_DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  if (N_DIGITS < 2 || PRESCALE < 2 || BLANK < 0 || BLANK >= PRESCALE || BLINK_LOG2 < 0) begin : g_param_check
    $error("display_mux_ctrl: illegal parameter combination");
  end

  logic [CNT_W-1:0]      cnt;
  logic [IDX_W-1:0]      idx;
  logic [5*N_DIGITS-1:0] active;
  logic [5*N_DIGITS-1:0] shadow;
  logic                  pending;
  logic                  frame_start;
  logic                  commit;
  logic                  frame_end;
  logic                  visible;
  logic [N_DIGITS-1:0]   onehot;
  logic [N_DIGITS-1:0]   sel_next;
  logic [4:0]            cur;

  assign frame_end = (cnt == CNT_LAST) && (idx == IDX_LAST);
  assign onehot    = {{(N_DIGITS-1){1'b0}}, 1'b1} << idx;
  assign cur       = active[5*idx +: 5];

  if (BLANK == 0) begin : g_no_blank
    assign visible = 1'b1;
  end else begin : g_blank
    assign visible = (cnt >= CNT_W'(BLANK));
  end

`ifdef DISPLAY_MUX_BLINK_EN
  logic [BLINK_LOG2:0] fcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      fcnt <= '0;
    end else if (frame_end) begin
      fcnt <= fcnt + 1'b1;
    end
  end

  assign sel_next = visible ? (onehot & ~({N_DIGITS{fcnt[BLINK_LOG2]}} & blink_mask)) : '0;
`else
  assign sel_next = visible ? onehot : '0;
`endif

  // frame_start/commit delay the frame-end pulses by one state cycle so that
  // frame_done/load_ack line up with the first output cycle of the new frame.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= '0;
      active      <= '0;
      shadow      <= '0;
      pending     <= 1'b0;
      frame_start <= 1'b0;
      commit      <= 1'b0;
      digit_sel   <= '0;
      diff        <= '0;
      sinal       <= 1'b0;
      frame_done  <= 1'b0;
      load_ack    <= 1'b0;
    end else begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end

      if (frame_end) begin
        if (load) begin
          active <= diff_in;
        end else if (pending) begin
          active <= shadow;
        end
        pending     <= 1'b0;
        frame_start <= 1'b1;
        commit      <= load | pending;
      end else begin
        if (load) begin
          shadow  <= diff_in;
          pending <= 1'b1;
        end
        frame_start <= 1'b0;
        commit      <= 1'b0;
      end

      digit_sel     <= sel_next;
      {sinal, diff} <= cur;
      frame_done    <= frame_start;
      load_ack      <= commit;
    end
  end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed, table-driven bench for display_mux_ctrl with N_DIGITS=4, PRESCALE=4, BLANK=1.
module tb_display_mux_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [19:0] diff_in = '0;
  logic [3:0]  diff;
  logic        sinal;
  logic [3:0]  digit_sel;
  logic        frame_done;
  logic        load_ack;
`ifdef DISPLAY_MUX_BLINK_EN
  logic [3:0]  blink_mask = '0;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  display_mux_ctrl #(
    .N_DIGITS  (4),
    .PRESCALE  (4),
    .BLANK     (1),
    .BLINK_LOG2(0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .diff_in   (diff_in),
`ifdef DISPLAY_MUX_BLINK_EN
    .blink_mask(blink_mask),
`endif
    .diff      (diff),
    .sinal     (sinal),
    .digit_sel (digit_sel),
    .frame_done(frame_done),
    .load_ack  (load_ack)
  );

  typedef struct {
    logic        ld;
    logic [19:0] din;
    logic [3:0]  sel;
    logic [3:0]  d;
    logic        s;
    logic        fd;
    logic        ack;
  } vec_t;

  vec_t tbl[25];

  function automatic vec_t v(input logic ld, input logic [19:0] din, input logic [3:0] sel,
                             input logic [3:0] d, input logic s, input logic fd, input logic ack);
    vec_t r;
    r.ld = ld; r.din = din; r.sel = sel; r.d = d; r.s = s; r.fd = fd; r.ack = ack;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs are applied for exactly one rising edge; outputs are sampled 1 time unit later.
  task automatic tick(input logic ld, input logic [19:0] din);
    load    = ld;
    diff_in = din;
    @(posedge clk);
    #1;
    load    = 1'b0;
    diff_in = '0;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      tick(1'b0, '0);
      chk("reset_sel", digit_sel, 0);
      chk("reset_diff", diff, 0);
      chk("reset_sinal", sinal, 0);
      chk("reset_frame_done", frame_done, 0);
      chk("reset_load_ack", load_ack, 0);
    end
    reset = 1'b0;
  endtask

  int ack_cnt;
  int nz_cnt;

  initial begin
    // Free-run first frame, with a load of {-1, +3} into digits 0/1 during slot 1.
    tbl[0]  = v(0, 20'h0, 4'b0000, 4'h0, 0, 0, 0);
    tbl[1]  = v(0, 20'h0, 4'b0001, 4'h0, 0, 0, 0);
    tbl[2]  = v(0, 20'h0, 4'b0001, 4'h0, 0, 0, 0);
    tbl[3]  = v(0, 20'h0, 4'b0001, 4'h0, 0, 0, 0);
    tbl[4]  = v(0, 20'h0, 4'b0000, 4'h0, 0, 0, 0);
    tbl[5]  = v(1, 20'h0007F, 4'b0010, 4'h0, 0, 0, 0);
    tbl[6]  = v(0, 20'h0, 4'b0010, 4'h0, 0, 0, 0);
    tbl[7]  = v(0, 20'h0, 4'b0010, 4'h0, 0, 0, 0);
    tbl[8]  = v(0, 20'h0, 4'b0000, 4'h0, 0, 0, 0);
    tbl[9]  = v(0, 20'h0, 4'b0100, 4'h0, 0, 0, 0);
    tbl[10] = v(0, 20'h0, 4'b0100, 4'h0, 0, 0, 0);
    tbl[11] = v(0, 20'h0, 4'b0100, 4'h0, 0, 0, 0);
    tbl[12] = v(0, 20'h0, 4'b0000, 4'h0, 0, 0, 0);
    tbl[13] = v(0, 20'h0, 4'b1000, 4'h0, 0, 0, 0);
    tbl[14] = v(0, 20'h0, 4'b1000, 4'h0, 0, 0, 0);
    tbl[15] = v(0, 20'h0, 4'b1000, 4'h0, 0, 0, 0);
    tbl[16] = v(0, 20'h0, 4'b0000, 4'hF, 1, 1, 1);
    tbl[17] = v(0, 20'h0, 4'b0001, 4'hF, 1, 0, 0);
    tbl[18] = v(0, 20'h0, 4'b0001, 4'hF, 1, 0, 0);
    tbl[19] = v(0, 20'h0, 4'b0001, 4'hF, 1, 0, 0);
    tbl[20] = v(0, 20'h0, 4'b0000, 4'h3, 0, 0, 0);
    tbl[21] = v(0, 20'h0, 4'b0010, 4'h3, 0, 0, 0);
    tbl[22] = v(0, 20'h0, 4'b0010, 4'h3, 0, 0, 0);
    tbl[23] = v(0, 20'h0, 4'b0010, 4'h3, 0, 0, 0);
    tbl[24] = v(0, 20'h0, 4'b0000, 4'h0, 0, 0, 0);

    do_reset(3);
    for (int k = 0; k < 25; k++) begin
      tick(tbl[k].ld, tbl[k].din);
      chk($sformatf("tbl%0d_sel", k + 1), digit_sel, tbl[k].sel);
      chk($sformatf("tbl%0d_diff", k + 1), diff, tbl[k].d);
      chk($sformatf("tbl%0d_sinal", k + 1), sinal, tbl[k].s);
      chk($sformatf("tbl%0d_frame_done", k + 1), frame_done, tbl[k].fd);
      chk($sformatf("tbl%0d_load_ack", k + 1), load_ack, tbl[k].ack);
    end
    for (int k = 26; k <= 60; k++) begin
      tick(1'b0, '0);
      chk($sformatf("period_fd_edge%0d", k), frame_done, (k == 33 || k == 49) ? 1 : 0);
      chk($sformatf("period_ack_edge%0d", k), load_ack, 0);
    end

    // Two loads in one frame: last one wins, single ack.
    do_reset(2);
    ack_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 3) tick(1'b1, 20'h00001);
      else if (k == 10) tick(1'b1, 20'h00002);
      else tick(1'b0, '0);
      if (load_ack === 1'b1) ack_cnt++;
      if (k == 17) chk("two_loads_ack_at_fd", {frame_done, load_ack}, 2'b11);
      if (k == 18) chk("two_loads_digit0", {sinal, diff}, 5'b00010);
    end
    chk("two_loads_ack_count", ack_cnt, 1);

    // Load on the frame-end cycle bypasses and discards an earlier shadow value.
    do_reset(2);
    ack_cnt = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k == 6) tick(1'b1, 20'h00001);
      else if (k == 16) tick(1'b1, 20'h00003);
      else tick(1'b0, '0);
      if (load_ack === 1'b1) ack_cnt++;
      if (k == 16) chk("e_load_old_digit3", {sinal, diff}, 5'b00000);
      if (k == 17) chk("e_load_ack_at_fd", {frame_done, load_ack}, 2'b11);
      if (k == 18) chk("e_load_digit0", {sinal, diff}, 5'b00011);
      if (k == 22) chk("e_load_digit1", {sinal, diff}, 5'b00000);
    end
    chk("e_load_ack_count", ack_cnt, 1);

    // Load in slot 2 then reset in slot 3: pending load discarded, never acked.
    do_reset(2);
    for (int k = 1; k <= 13; k++) begin
      if (k == 10) tick(1'b1, 20'hFFFFF);
      else tick(1'b0, '0);
    end
    do_reset(3);
    ack_cnt = 0;
    nz_cnt = 0;
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, '0);
      if (load_ack === 1'b1) ack_cnt++;
      if ({sinal, diff} !== 5'b00000) nz_cnt++;
    end
    chk("reset_drop_ack_count", ack_cnt, 0);
    chk("reset_drop_nonzero_digits", nz_cnt, 0);

`ifdef DISPLAY_MUX_BLINK_EN
    // Blink with one-frame half-period: digit 0 dark on odd frames only.
    blink_mask = 4'b0001;
    do_reset(2);
    for (int k = 1; k <= 40; k++) begin
      tick(1'b0, '0);
      if (k == 2)  chk("blink_f0_digit0", digit_sel, 4'b0001);
      if (k == 18) chk("blink_f1_digit0", digit_sel, 4'b0000);
      if (k == 22) chk("blink_f1_digit1", digit_sel, 4'b0010);
      if (k == 34) chk("blink_f2_digit0", digit_sel, 4'b0001);
    end
    blink_mask = 4'b0000;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
